// File: rtl/vectored_irq_ctrl.sv
// Vectored interrupt controller for the single-cycle MIPS core.
// Latches rising edges of N_IRQ sources into pending bits, masks them, picks
// the lowest-index eligible channel and redirects the PC to its vector slot.
// One level of service: further interrupts are held off until JEPC (eret).

// Per-channel request cell: edge detector plus sticky pending bit.
module vic_chan (
   input  logic clk,
   input  logic reset,
   input  logic irq_i,
   input  logic clr_i,
   output logic pending_o
);
   logic irq_q;
   logic pend_q, pend_d;
   logic rise;

   // A new rising edge wins over a same-cycle clear, so the request is never lost.
   always_comb begin
      rise   = irq_i & ~irq_q;
      pend_d = rise | (pend_q & ~clr_i);
   end

   // Source delay line for edge detection and the pending bit itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         irq_q  <= irq_i;
         pend_q <= pend_d;
      end
   end

   assign pending_o = pend_q;
endmodule

module vectored_irq_ctrl #(
   parameter int          N_IRQ      = 4,
   parameter logic [31:0] VEC_BASE   = 32'h0000_01F0,
   parameter logic [31:0] VEC_STRIDE = 32'd4,
   localparam int         ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wd,
   input  logic             eret,
   input  logic [31:0]      pc_next,
   output logic             take,
   output logic [31:0]      vector_addr,
   output logic [31:0]      epc,
   output logic [ID_W-1:0]  active_id,
   output logic             in_service,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] mask
);
   typedef enum logic {S_IDLE, S_SERVICE} state_t;

   state_t           state_q, state_d;
   logic [N_IRQ-1:0] mask_q, mask_d;
   logic [31:0]      epc_q, epc_d;
   logic [ID_W-1:0]  active_id_q, active_id_d;

   logic [N_IRQ-1:0] pend;
   logic [N_IRQ-1:0] eligible;
   logic [N_IRQ-1:0] clr;
   logic [ID_W-1:0]  winner;
   logic             any_elig;

   // Per-channel edge detect and pending storage.
   for (genvar g = 0; g < N_IRQ; g++) begin : g_chan
      vic_chan u_chan (
         .clk       (clk),
         .reset     (reset),
         .irq_i     (irq[g]),
         .clr_i     (clr[g]),
         .pending_o (pend[g])
      );
   end

   // Fixed priority: lowest eligible index wins.
   always_comb begin
      eligible = pend & mask_q;
      winner   = '0;
      any_elig = 1'b0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (eligible[i] && !any_elig) begin
            winner   = ID_W'(i);
            any_elig = 1'b1;
         end
      end
   end

   // Mask register: a write takes effect on eligibility from the next cycle.
   always_comb begin
      mask_d = mask_q;
      if (mask_we) mask_d = mask_wd;
   end

   // FSM next state, take decision, EPC/id capture and pending clear.
   always_comb begin
      state_d     = state_q;
      epc_d       = epc_q;
      active_id_d = active_id_q;
      take        = 1'b0;
      clr         = '0;
      unique case (state_q)
         S_IDLE: begin
            // eret while idle has no meaning and is ignored.
            if (any_elig) begin
               take        = 1'b1;
               clr[winner] = 1'b1;
               epc_d       = pc_next;
               active_id_d = winner;
               state_d     = S_SERVICE;
            end
         end
         S_SERVICE: begin
            // Returning to IDLE first lets the instruction at epc execute
            // before any queued request can be taken.
            if (eret) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Vector slot of the winner; parked at VEC_BASE while nothing is taken.
   always_comb begin
      vector_addr = VEC_BASE;
      if (take) vector_addr = VEC_BASE + (32'(winner) * VEC_STRIDE);
   end

   // Controller state registers; reset drops to IDLE with everything enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mask_q      <= '1;
         epc_q       <= '0;
         active_id_q <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         epc_q       <= epc_d;
         active_id_q <= active_id_d;
      end
   end

   assign epc        = epc_q;
   assign active_id  = active_id_q;
   assign in_service = (state_q == S_SERVICE);
   assign pending    = pend;
   assign mask       = mask_q;
endmodule

// File: tb/tb_vectored_irq_ctrl.sv
// Scoreboard bench for vectored_irq_ctrl: directed scenarios then random traffic,
// expectations from a transaction-level model of the controller.
module tb_vectored_irq_ctrl;
   localparam int          N  = 4;
   localparam logic [31:0] VB = 32'h0000_01F0;
   localparam logic [31:0] VS = 32'd4;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  irq;
   logic          mask_we;
   logic [N-1:0]  mask_wd;
   logic          eret;
   logic [31:0]   pc_next;
   logic          take;
   logic [31:0]   vector_addr;
   logic [31:0]   epc;
   logic [1:0]    active_id;
   logic          in_service;
   logic [N-1:0]  pending;
   logic [N-1:0]  mask;

   int checks   = 0;
   int failures = 0;

   vectored_irq_ctrl #(.N_IRQ(N), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
      .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_wd(mask_wd),
      .eret(eret), .pc_next(pc_next), .take(take), .vector_addr(vector_addr),
      .epc(epc), .active_id(active_id), .in_service(in_service),
      .pending(pending), .mask(mask)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         take;
      logic [31:0]  vec;
      logic [31:0]  epc;
      logic [1:0]   id;
      logic         svc;
      logic [N-1:0] pend;
      logic [N-1:0] mask;
   } exp_t;

   exp_t q[$];

   // Model: what the controller has latched, as plain variables.
   logic [N-1:0] m_pend, m_mask, m_prev;
   logic         m_svc;
   logic [31:0]  m_epc;
   int           m_id;

   function automatic int first_set(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic exp_t predict();
      exp_t e;
      int   w;
      w      = first_set(m_pend & m_mask);
      e.take = !m_svc && (w >= 0);
      e.vec  = e.take ? VB + 32'(w) * VS : VB;
      e.epc  = m_epc;
      e.id   = 2'(m_id);
      e.svc  = m_svc;
      e.pend = m_pend;
      e.mask = m_mask;
      return e;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '1; m_prev = '0; m_svc = 1'b0; m_epc = '0; m_id = 0;
   endtask

   task automatic model_step(input logic [N-1:0] irq_v, input logic we,
                             input logic [N-1:0] wd, input logic er, input logic [31:0] pc);
      int w;
      logic [N-1:0] rise;
      w    = first_set(m_pend & m_mask);
      rise = irq_v & ~m_prev;
      if (!m_svc && w >= 0) begin
         m_epc     = pc;
         m_id      = w;
         m_svc     = 1'b1;
         m_pend[w] = 1'b0;
      end else if (m_svc && er) begin
         m_svc = 1'b0;
      end
      m_pend = m_pend | rise;
      if (we) m_mask = wd;
      m_prev = irq_v;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s @%0t: got=%h expected=%h", name, $time, act, exp_v);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_take", 32'(take), 32'd0);
      chk("rst_vector", vector_addr, VB);
      chk("rst_epc", epc, 32'd0);
      chk("rst_active_id", 32'(active_id), 32'd0);
      chk("rst_in_service", 32'(in_service), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_mask", 32'(mask), 32'hF);
   endtask

   // One clock of stimulus: expectation queued, inputs applied, model advanced at the edge.
   task automatic cyc(input logic [N-1:0] irq_v, input logic we = 1'b0,
                      input logic [N-1:0] wd = '0, input logic er = 1'b0,
                      input logic [31:0] pc = 32'h0);
      irq = irq_v; mask_we = we; mask_wd = wd; eret = er; pc_next = pc;
      q.push_back(predict());
      @(posedge clk);
      model_step(irq_v, we, wd, er, pc);
      #1;
   endtask

   task automatic idle(input int n, input logic [N-1:0] irq_v);
      for (int i = 0; i < n; i++) cyc(irq_v, 1'b0, '0, 1'b0, 32'h100 + 32'(i * 4));
   endtask

   // Monitor: every non-reset cycle the DUT presents a full output set.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && q.size() != 0) begin
         e = q.pop_front();
         chk("take", 32'(take), 32'(e.take));
         chk("vector_addr", vector_addr, e.vec);
         chk("epc", epc, e.epc);
         chk("active_id", 32'(active_id), 32'(e.id));
         chk("in_service", 32'(in_service), 32'(e.svc));
         chk("pending", 32'(pending), 32'(e.pend));
         chk("mask", 32'(mask), 32'(e.mask));
      end
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] r_irq;
      reset = 1'b1; irq = '0; mask_we = 1'b0; mask_wd = '0; eret = 1'b0; pc_next = '0;
      model_reset();
      #2;
      chk_reset_vals();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      idle(2, 4'b0000);

      // 1: single request on ch2
      cyc(4'b0100, 1'b0, '0, 1'b0, 32'h10);
      cyc(4'b0100, 1'b0, '0, 1'b0, 32'h20);
      idle(3, 4'b0000);
      cyc(4'b0000, 1'b0, '0, 1'b1, 32'h24);
      idle(2, 4'b0000);

      // 2: simultaneous ch1/ch3, priority then queued service
      cyc(4'b1010, 1'b0, '0, 1'b0, 32'h30);
      idle(3, 4'b0000);
      cyc(4'b0000, 1'b0, '0, 1'b1, 32'h40);
      idle(3, 4'b0000);
      cyc(4'b0000, 1'b0, '0, 1'b1, 32'h50);
      idle(2, 4'b0000);

      // 3: masked request held pending, unmask releases it
      cyc(4'b0000, 1'b1, 4'b1110, 1'b0, 32'h60);
      cyc(4'b0001, 1'b0, '0, 1'b0, 32'h64);
      idle(3, 4'b0000);
      cyc(4'b0000, 1'b1, 4'b1111, 1'b0, 32'h70);
      idle(3, 4'b0000);
      cyc(4'b0000, 1'b0, '0, 1'b1, 32'h80);
      idle(2, 4'b0000);

      // 4: two edges on ch2 during service collapse into one pending
      cyc(4'b1000, 1'b0, '0, 1'b0, 32'h90);
      idle(1, 4'b0000);
      cyc(4'b0100); cyc(4'b0000); cyc(4'b0100); cyc(4'b0000);
      cyc(4'b0000, 1'b0, '0, 1'b1, 32'hA0);
      idle(3, 4'b0000);
      cyc(4'b0000, 1'b0, '0, 1'b1, 32'hB0);
      idle(2, 4'b0000);

      // 5: level-high source takes once; eret while idle is ignored
      idle(10, 4'b0010);
      cyc(4'b0010, 1'b0, '0, 1'b1, 32'hC0);
      idle(2, 4'b0010);
      cyc(4'b0010, 1'b0, '0, 1'b1, 32'hC8);
      idle(3, 4'b0000);

      // 6: reset in the middle of a handler with pending=0110
      cyc(4'b0001, 1'b0, '0, 1'b0, 32'hD0);
      idle(1, 4'b0000);
      cyc(4'b0110); cyc(4'b0000);
      reset = 1'b1;
      #1;
      chk_reset_vals();
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      idle(4, 4'b0000);
      cyc(4'b1000, 1'b0, '0, 1'b0, 32'hE0);
      idle(2, 4'b0000);
      cyc(4'b0000, 1'b0, '0, 1'b1, 32'hE4);
      idle(2, 4'b0000);

      // Random traffic
      r_irq = '0;
      for (int c = 0; c < 2000; c++) begin
         logic we, er;
         for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
         we = ($urandom_range(0, 19) == 0);
         er = m_svc ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
         cyc(r_irq, we, 4'($urandom), er, $urandom);
      end
      idle(2, 4'b0000);

      chk("queue_drain", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
